uart_receiver: RTL and testbench
================================

# uart_receiver

Receive-only UART with an integrated baud-rate tick generator and a receive FIFO. It oversamples the serial `rx` line at 16x the bit rate and deserialises 8N1 frames, LSB first. Each completed byte is pushed into a small FIFO that the host drains with a read strobe. It sits between the board's serial input pin and downstream consumers such as the 7-segment display logic.

## Interface
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: oversampling ticks for the stop bit (16 = 1 stop bit).
- `DVSR`, 326: clocks per oversampling tick (50 MHz / (16·326) ≈ 9600 baud).
- `DVSR_WIDTH`, 9: width of the baud counter; must satisfy 2^DVSR_WIDTH > DVSR-1.
- `FIFO_W`, 2: FIFO address width; depth = 2^FIFO_W = 4 entries.
- `clk` in 1: single system clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `rd_uart` in 1: read strobe; pops one entry when FIFO not empty.
- `rx` in 1: serial input, idle high.
- `rd_data` out DBIT: registered read data, loaded on a pop.
- `rx_empty` out 1: FIFO empty flag.

## Operation
- Internal nets: `s_tick` (baud tick), `rx_done_tick`, `dout` (receiver byte). The FIFO instance is `m2`, with `full`, `wr_ptr`, `rd_ptr`. The bench probes these names hierarchically.
- **rx input:** `rx` passes through a 2-FF synchroniser, reset value 1.
- **Baud generator:**
  - Counter runs 0..DVSR-1 and wraps.
  - `s_tick` = 1 for one clk when count == DVSR-1, giving one tick every DVSR clocks.
  - Free-running; never gated by the receiver.
- **Receiver FSM states:** IDLE, START, DATA, STOP. Tick counter `s` is 4-bit; bit counter `n` is 0..DBIT-1.
  - IDLE: when synced rx == 0, go to START with s = 0.
  - START: on each tick, if s == 7, sample rx. If rx == 0, go to DATA with s = 0, n = 0. If rx == 1, treat it as a glitch and return to IDLE. Otherwise s++.
  - DATA: on each tick, if s == 15, shift `b = {rx, b[DBIT-1:1]}` and set s = 0. If n == DBIT-1, go to STOP; else n++. Otherwise s++.
  - STOP: on each tick, if s == SB_TICK-1, go to IDLE and pulse `rx_done_tick` for one clk. Otherwise s++.
  - The stop-bit value is not checked; there is no framing error output.
  - `dout` = the shift register `b`.
- **FIFO:**
  - 2^FIFO_W × DBIT storage.
  - Write when `rx_done_tick` is high and not full.
  - Read when `rd_uart` is high and not empty. A read copies mem[rd_ptr] into the `rd_data` register and advances `rd_ptr`.
  - Pointers wrap modulo 2^FIFO_W. Full and empty are registered flags updated on each operation.
  - Write while full: byte dropped, no state change.
  - Read while empty: ignored, `rd_data` holds.
  - Simultaneous read and write when neither empty nor full: both pointers advance, flags unchanged.
  - Simultaneous read and write when empty: write only.
  - Simultaneous read and write when full: both proceed, full clears and is set again, net full.
- **Reset (async, any time including mid-frame):**
  - FSM → IDLE; s, n, b = 0; baud counter = 0.
  - Pointers = 0, full = 0, empty = 1.
  - `rd_data` = 0, `rx_empty` = 1.

## Timing
- `s_tick` period is exactly DVSR clks. The first tick comes DVSR clks after reset release.
- Data bits are sampled near mid-bit: 8 ticks into the start bit, then every 16 ticks.
- `rx_done_tick` fires mid-stop-bit: 8 + 16·DBIT + SB_TICK ticks after the start edge is detected.
- `rx_empty` falls on the clk edge after `rx_done_tick`.
- `rd_data` is valid on the clk edge that samples `rd_uart` = 1 and is visible from the following cycle. It is held until the next successful pop.
- `rx_empty` rises on the same edge as a pop that removes the last entry.
- Back-to-back frames are supported: IDLE accepts a new start bit immediately after the stop-bit tick.

## Test plan
- **Reset:** assert `rst_n` = 0 for 100 ns → `rd_data` = 0x00, `rx_empty` = 1, `full` = 0, `wr_ptr` = `rd_ptr` = 0, no `rx_done_tick`.
- **Baud:** free-run → `s_tick` pulses exactly every 326 clks (6520 ns at 50 MHz).
- **Single bytes:** send 8N1 frames 'M' (0x4D), 'P' (0x50), 'G' (0x47), with bit period 326·16·20 ns. For each frame:
  - Expect `rx_done_tick` with `dout` equal to the byte, then `rx_empty` = 0.
  - Pulse `rd_uart` for 1 clk → `rd_data` equals the byte and `rx_empty` = 1.
- **Overflow:** send 0x11, 0x22, 0x33, 0x44, 0x55 with no reads → `full` = 1 after the 4th byte and the 5th is dropped. Four reads return 0x11, 0x22, 0x33, 0x44, then `rx_empty` = 1.
- **Empty read:** pulse `rd_uart` while empty → `rd_data` unchanged, pointers unchanged.
- **Glitch and reset:**
  - A 2-tick low pulse on idle `rx` → FSM returns to IDLE with no `rx_done_tick`.
  - Assert `rst_n` mid-frame, then send 0xA5 → 0xA5 is received correctly.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Host-side read port of the UART receiver: read strobe, read data and empty flag.
interface uart_receiver_if #(
    parameter int unsigned DBIT = 8
);
    logic            rd_uart;
    logic [DBIT-1:0] rd_data;
    logic            rx_empty;

    // Host drives the read strobe and consumes data/status.
    modport master (
        output rd_uart,
        input  rd_data,
        input  rx_empty
    );

    // Receiver returns data/status and accepts the read strobe.
    modport slave (
        input  rd_uart,
        output rd_data,
        output rx_empty
    );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling baud generator and a small receive FIFO.

// Receive FIFO with registered read data and registered full/empty flags.
module uart_rx_fifo #(
    parameter int unsigned DBIT   = 8,
    parameter int unsigned FIFO_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr,
    input  logic            rd,
    input  logic [DBIT-1:0] w_data,
    output logic [DBIT-1:0] r_data,
    output logic            empty
);
    localparam int unsigned DEPTH = 2 ** FIFO_W;

    logic [DBIT-1:0]   mem [DEPTH];
    logic [FIFO_W-1:0] wr_ptr;
    logic [FIFO_W-1:0] rd_ptr;
    logic [FIFO_W-1:0] wr_ptr_succ;
    logic [FIFO_W-1:0] rd_ptr_succ;
    logic              full;
    logic              wr_en;
    logic              rd_en;

    // A write into a full FIFO is allowed only when a pop frees a slot on the same edge.
    assign rd_en       = rd && !empty;
    assign wr_en       = wr && (!full || rd_en);
    assign wr_ptr_succ = wr_ptr + FIFO_W'(1);
    assign rd_ptr_succ = rd_ptr + FIFO_W'(1);

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= w_data;
        end
    end

    // Pointers, flags and read data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            r_data <= '0;
        end else begin
            if (rd_en) begin
                r_data <= mem[rd_ptr];
                rd_ptr <= rd_ptr_succ;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr_succ;
            end
            case ({wr_en, rd_en})
                2'b10: begin
                    empty <= 1'b0;
                    full  <= (wr_ptr_succ == rd_ptr);
                end
                2'b01: begin
                    full  <= 1'b0;
                    empty <= (rd_ptr_succ == wr_ptr);
                end
                default: ;
            endcase
        end
    end
endmodule

module uart_receiver #(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned DVSR       = 326,
    parameter int unsigned DVSR_WIDTH = 9,
    parameter int unsigned FIFO_W     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    uart_receiver_if.slave host
);
    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic                  rx_meta_q;
    logic                  rx_sync_q;
    logic [DVSR_WIDTH-1:0] baud_q;
    logic [DVSR_WIDTH-1:0] baud_d;
    logic                  s_tick;
    state_t                state_q;
    logic [3:0]            s_q;
    logic [NW-1:0]         n_q;
    logic [DBIT-1:0]       b_q;
    logic                  done_q;
    logic                  rx_done_tick;
    logic [DBIT-1:0]       dout;

    // Two-flop synchroniser for the asynchronous serial line, idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Free-running oversampling tick: one pulse every DVSR clocks.
    assign s_tick = (baud_q == DVSR_WIDTH'(DVSR - 1));
    assign baud_d = s_tick ? '0 : baud_q + DVSR_WIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q <= '0;
        end else begin
            baud_q <= baud_d;
        end
    end

    // Frame deserialiser: mid-bit sampling driven by the oversampling tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_sync_q) begin
                        state_q <= START;
                        s_q     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_q == 4'd7) begin
                            if (!rx_sync_q) begin
                                state_q <= DATA;
                                s_q     <= '0;
                                n_q     <= '0;
                            end else begin
                                // Line went back high before mid start bit: glitch.
                                state_q <= IDLE;
                            end
                        end else begin
                            s_q <= s_q + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_q == 4'd15) begin
                            s_q <= '0;
                            b_q <= {rx_sync_q, b_q[DBIT-1:1]};
                            if (n_q == NW'(DBIT - 1)) begin
                                state_q <= STOP;
                            end else begin
                                n_q <= n_q + NW'(1);
                            end
                        end else begin
                            s_q <= s_q + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s_q == 4'(SB_TICK - 1)) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            s_q <= s_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_done_tick = done_q;
    assign dout         = b_q;

    // Completed bytes queue up for the host.
    uart_rx_fifo #(
        .DBIT   (DBIT),
        .FIFO_W (FIFO_W)
    ) m2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr     (rx_done_tick),
        .rd     (host.rd_uart),
        .w_data (dout),
        .r_data (host.rd_data),
        .empty  (host.rx_empty)
    );
endmodule

// File: tb/tb_uart_receiver.sv
// Randomised bench for uart_receiver against a queue-based model of the receive path.
module tb_uart_receiver;
    localparam int unsigned DBIT    = 8;
    localparam int unsigned SB_TICK = 16;
    localparam int unsigned DVSR    = 5;
    localparam int unsigned DVSR_W  = 3;
    localparam int unsigned FIFO_W  = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int          BIT     = 16 * DVSR;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;

    uart_receiver_if #(.DBIT(DBIT)) bus ();

    uart_receiver #(
        .DBIT       (DBIT),
        .SB_TICK    (SB_TICK),
        .DVSR       (DVSR),
        .DVSR_WIDTH (DVSR_W),
        .FIFO_W     (FIFO_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .host  (bus.slave)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model of what the host should see: pending bytes, last popped byte, pointer counts.
    logic [7:0] mdl_q [$];
    logic [7:0] mdl_rd;
    int         wr_cnt;
    int         rd_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        mdl_q.delete();
        mdl_rd = 8'h00;
        wr_cnt = 0;
        rd_cnt = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        bus.rd_uart = 1'b0;
        #100;
        check("rst_rd_data", 32'(bus.rd_data), 32'h00);
        check("rst_rx_empty", 32'(bus.rx_empty), 32'd1);
        check("rst_full", 32'(dut.m2.full), 32'd0);
        check("rst_wr_ptr", 32'(dut.m2.wr_ptr), 32'd0);
        check("rst_rd_ptr", 32'(dut.m2.rd_ptr), 32'd0);
        check("rst_done", 32'(dut.rx_done_tick), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_fifo_state(input string tag);
        check({tag, "_rx_empty"}, 32'(bus.rx_empty), 32'(mdl_q.size() == 0));
        check({tag, "_full"}, 32'(dut.m2.full), 32'(mdl_q.size() == DEPTH));
        check({tag, "_rd_data"}, 32'(bus.rd_data), 32'(mdl_rd));
        check({tag, "_wr_ptr"}, 32'(dut.m2.wr_ptr), 32'(wr_cnt % DEPTH));
        check({tag, "_rd_ptr"}, 32'(dut.m2.rd_ptr), 32'(rd_cnt % DEPTH));
    endtask

    // Host read strobe for one clock.
    task automatic host_read();
        bus.rd_uart = 1'b1;
        cyc(1);
        bus.rd_uart = 1'b0;
        if (mdl_q.size() > 0) begin
            mdl_rd = mdl_q.pop_front();
            rd_cnt++;
        end
        check_fifo_state("read");
    endtask

    // One 8N1 frame; optionally strobes a read on the same edge that writes the byte.
    task automatic send_byte(input logic [7:0] b, input bit rd_at_done);
        bit seen;
        int k;
        rx = 1'b0;
        cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cyc(BIT);
        end
        rx = 1'b1;
        seen = 1'b0;
        k = 0;
        while (!seen && k < BIT) begin
            if (dut.rx_done_tick) begin
                seen = 1'b1;
            end else begin
                cyc(1);
                k++;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("dout", 32'(dut.dout), 32'(b));
            bus.rd_uart = rd_at_done;
            cyc(1);
            k++;
            bus.rd_uart = 1'b0;
            if (rd_at_done && mdl_q.size() > 0) begin
                mdl_rd = mdl_q.pop_front();
                rd_cnt++;
            end
            if (mdl_q.size() < DEPTH) begin
                mdl_q.push_back(b);
                wr_cnt++;
            end
            check("done_done_low", 32'(dut.rx_done_tick), 32'd0);
            check_fifo_state("write");
        end
        if (BIT - k > 0) cyc(BIT - k);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] single [3];
        int         cnt;
        int         seen_cnt;
        bit         got_tick;

        single[0] = 8'h4D;
        single[1] = 8'h50;
        single[2] = 8'h47;
        bus.rd_uart = 1'b0;
        model_reset();

        apply_reset();

        // Baud tick spacing.
        for (int p = 0; p < 3; p++) begin
            got_tick = 1'b0;
            cnt = 0;
            while (!got_tick && cnt < 4 * DVSR) begin
                cyc(1);
                cnt++;
                got_tick = dut.s_tick;
            end
            cnt = 0;
            got_tick = 1'b0;
            while (!got_tick && cnt < 4 * DVSR) begin
                cyc(1);
                cnt++;
                got_tick = dut.s_tick;
            end
            check("tick_period", 32'(cnt), 32'(DVSR));
        end
        cyc(BIT);

        // Single bytes, each drained immediately.
        for (int i = 0; i < 3; i++) begin
            send_byte(single[i], 1'b0);
            host_read();
            check("single_byte", 32'(bus.rd_data), 32'(single[i]));
        end

        // Overflow: fifth byte dropped.
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i * 8'h11), 1'b0);
        end
        check("ovf_full", 32'(dut.m2.full), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            host_read();
            check("ovf_read", 32'(bus.rd_data), 32'(i * 8'h11));
        end
        check("ovf_drained", 32'(bus.rx_empty), 32'd1);

        // Read while empty must not disturb anything.
        host_read();
        check("empty_read_hold", 32'(bus.rd_data), 32'h44);

        // Short low glitch on an idle line.
        rx = 1'b0;
        cyc(2 * DVSR);
        rx = 1'b1;
        seen_cnt = 0;
        for (int i = 0; i < 12 * BIT; i++) begin
            cyc(1);
            if (dut.rx_done_tick) seen_cnt++;
        end
        check("glitch_no_done", 32'(seen_cnt), 32'd0);
        check_fifo_state("glitch");
        send_byte(8'h3C, 1'b0);
        host_read();

        // Reset in the middle of a frame, then a clean frame.
        rx = 1'b0;
        cyc(BIT);
        rx = 1'b1;
        cyc(BIT);
        rx = 1'b0;
        cyc(2 * BIT);
        apply_reset();
        cyc(BIT);
        send_byte(8'hA5, 1'b0);
        host_read();
        check("post_reset_byte", 32'(bus.rd_data), 32'hA5);

        // Random frames with random reads, including reads coinciding with writes.
        for (int f = 0; f < 12; f++) begin
            send_byte(8'($urandom_range(255)), ($urandom_range(2) == 0));
            for (int r = 0; r < int'($urandom_range(2)); r++) begin
                host_read();
            end
        end
        while (mdl_q.size() > 0) begin
            host_read();
        end
        check("final_empty", 32'(bus.rx_empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
